multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 157 +++++++++++++++
 tb/tb_multdiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply / divide unit: one bit per clock, 32 iteration
// edges per operation, registered result, error flag and one-cycle completion strobe.
module multdiv_unit (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] data_operandA,
    input  logic signed [31:0] data_operandB,
    input  logic               ctrl_MULT,
    input  logic               ctrl_DIV,
    output logic signed [31:0] data_result,
    output logic               data_exception,
    output logic               data_resultRDY
);

    localparam int DATA_W = 32;
    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic start;
    logic finish;

    // Iteration datapath: {acc_q, lo_q} is the shifting product or remainder/quotient pair
    logic [DATA_W-1:0] acc_q, lo_q;
    logic [DATA_W-1:0] acc_n, lo_n;
    logic [DATA_W-1:0] mag_a_q, mag_b_q;
    logic              neg_q;
    logic              b_zero_q;

    logic [DATA_W:0]   mult_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic              div_ge;
    logic              unused_diff_msb;

    logic [DATA_W:0]   fin;
    logic [DATA_W-1:0] fin_res;
    logic              fin_exc;

    function automatic logic [DATA_W-1:0] mag_of(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    // Returns {exception, result}; exception when bits 63:31 are not a pure sign extension.
    function automatic logic [DATA_W:0] fin_mult(input logic [2*DATA_W-1:0] mag,
                                                 input logic neg);
        logic signed [2*DATA_W-1:0] prod;
        logic [DATA_W:0] hi;
        prod = neg ? -$signed(mag) : $signed(mag);
        hi   = prod[2*DATA_W-1:DATA_W-1];
        return {~((&hi) | ~(|hi)), prod[DATA_W-1:0]};
    endfunction

    // Returns {exception, result}; a positive quotient of 2^31 (MIN / -1) wraps and flags.
    function automatic logic [DATA_W:0] fin_div(input logic [DATA_W-1:0] q,
                                                input logic neg,
                                                input logic b_zero);
        logic signed [DATA_W-1:0] qs;
        qs = neg ? -$signed(q) : $signed(q);
        if (b_zero) begin
            return {1'b1, {DATA_W{1'b0}}};
        end
        return {~neg & q[DATA_W-1], qs};
    endfunction

    assign start = ctrl_MULT | ctrl_DIV;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        if (start) begin
            state_d = ctrl_MULT ? MULT : DIV;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MULT, DIV: begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_resultRDY <= finish;
            if (finish) begin
                data_result    <= fin_res;
                data_exception <= fin_exc;
            end
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mult_sum  = {1'b0, acc_q} + ({1'b0, mag_a_q} & {(DATA_W+1){lo_q[0]}});
        div_shift = {acc_q, lo_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        if (state_q == DIV) begin
            acc_n = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            lo_n  = {lo_q[DATA_W-2:0], div_ge};
        end else begin
            acc_n = mult_sum[DATA_W:1];
            lo_n  = {mult_sum[0], lo_q[DATA_W-1:1]};
        end
    end

    // The remainder always fits in 32 bits once the trial subtraction succeeds
    assign unused_diff_msb = div_diff[DATA_W];

    always_comb begin
        if (state_q == MULT) begin
            fin = fin_mult({acc_n, lo_n}, neg_q);
        end else begin
            fin = fin_div(lo_n, neg_q, b_zero_q);
        end
        fin_exc = fin[DATA_W];
        fin_res = fin[DATA_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (start) begin
            mag_a_q  <= mag_of(data_operandA);
            mag_b_q  <= mag_of(data_operandB);
            neg_q    <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            b_zero_q <= (data_operandB == '0);
            acc_q    <= '0;
            lo_q     <= ctrl_MULT ? mag_of(data_operandB) : mag_of(data_operandA);
        end else if (state_q == MULT || state_q == DIV) begin
            acc_q <= acc_n;
            lo_q  <= lo_n;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: driver issues operations and queues expected
// results from a plain-arithmetic model; a negedge monitor pops and compares on each strobe.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        longint      due;
    } exp_t;

    exp_t   sb[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    logic [31:0] held_res = '0;
    logic        held_exc = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: exact 64-bit arithmetic, then check whether the value fits in signed 32 bits.
    function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa, sbv, p, q;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (mul) begin
            p = sa * sbv;
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sbv == 0) begin
            r = 32'h0;
            e = 1'b1;
        end else begin
            q = sa / sbv;
            r = q[31:0];
            e = (q > 64'sd2147483647);
        end
    endfunction

    // Monitor: reset values, strobe contents/latency, hold between strobes, missed strobes.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            chk("reset_result", data_result, 0);
            chk("reset_exception", data_exception, 0);
            chk("reset_rdy", data_resultRDY, 0);
            held_res = '0;
            held_exc = 1'b0;
        end else if (data_resultRDY) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: strobe at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("strobe_latency", cyc, e.due);
                chk("result", data_result, e.res);
                chk("exception", data_exception, e.exc);
                held_res = e.res;
                held_exc = e.exc;
            end
        end else begin
            chk("hold_result", data_result, held_res);
            chk("hold_exception", data_exception, held_exc);
            if (sb.size() > 0 && cyc > sb[0].due) begin
                n_cmp++;
                n_err++;
                $display("FAIL missed_strobe: no strobe by cycle %0d, expected at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // Called just after a negedge; next start edge comes 'gap' edges after this one.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input int gap);
        exp_t        e;
        logic [31:0] r;
        logic        x;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (gap >= 33) begin
            model(m, a, b, r, x);
            e.res = r;
            e.exc = x;
            e.due = cyc + 33;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        repeat (gap - 1) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] specials [8];
        logic [31:0] a, b;
        int          kind, gap, strobes;
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                     32'h7FFFFFFF, 32'h2, 32'hFFFFFFF9, 32'h64};

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;

        // Start on the very first edge after reset release
        issue(1, 0, 32'd7, 32'hFFFFFFFD, 40);
        issue(1, 0, 32'h00010000, 32'h00010000, 40);
        issue(0, 1, 32'hFFFFFFF9, 32'd2, 40);
        issue(0, 1, 32'd5, 32'd0, 40);
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 40);
        issue(0, 1, 32'h80000000, 32'd1, 40);
        issue(1, 0, 32'h80000000, 32'h80000000, 40);
        issue(1, 0, 32'h80000000, 32'hFFFFFFFF, 40);
        issue(1, 1, 32'd6, 32'd3, 40);

        // Restart mid-operation: only the divide completes
        issue(1, 0, 32'd3, 32'd4, 10);
        issue(0, 1, 32'd100, 32'd7, 40);
        // Start on the would-be completion edge aborts; start in DONE is accepted
        issue(1, 0, 32'd5, 32'd5, 32);
        issue(0, 1, 32'hFFFFFF9C, 32'd3, 40);
        issue(1, 0, 32'hFFFFFFF7, 32'd9, 33);
        issue(0, 1, 32'h7FFFFFFF, 32'hFFFFFFFE, 40);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = specials[$urandom_range(0, 7)];
            else if (kind == 1 && $urandom_range(0, 1) == 0) b = $urandom_range(1, 300);
            else b = $urandom;
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 32) : $urandom_range(33, 36);
            issue(kind != 1, kind != 0, a, b, gap);
        end

        // Asynchronous reset in the middle of a multiply
        issue(1, 0, 32'd7, 32'hFFFFFFFD, 40);
        issue(1, 0, 32'h12345, 32'h6789, 15);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_result", data_result, 0);
        chk("async_reset_exception", data_exception, 0);
        chk("async_reset_rdy", data_resultRDY, 0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        strobes = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) strobes++;
        end
        chk("no_strobe_after_reset", strobes, 0);

        issue(0, 1, 32'd1000, 32'hFFFFFFF9, 40);
        repeat (5) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
